// File: rtl/deck_shuffler.sv
`timescale 1ns/1ps
// Deck shuffler: Fisher-Yates shuffle of eight symbol pairs over 16 slots,
// using a free-running 16-bit Fibonacci LFSR with rejection sampling.
module deck_shuffler #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [63:0] card_map
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [63:0] INIT_MAP = 64'h7766554433221100;

  typedef enum logic [2:0] {IDLE, FILL, DRAW, SWAP, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [3:0]  i;
  logic [3:0]  j;
  logic [3:0]  mask;
  logic [3:0]  r;
  logic        draw_ok;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Smallest all-ones mask covering i keeps the rejection rate below one half.
  always_comb begin
    mask = 4'h1;
    if (i >= 4'd8)      mask = 4'hF;
    else if (i >= 4'd4) mask = 4'h7;
    else if (i >= 4'd2) mask = 4'h3;
    r       = lfsr[3:0] & mask;
    draw_ok = (r <= i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    state_nxt = DRAW;
      DRAW:    if (draw_ok) state_nxt = SWAP;
      SWAP:    state_nxt = (i == 4'd1) ? DONE : DRAW;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == FILL) || (state == DRAW) || (state == SWAP);
  assign done = (state == DONE);

  // valid rises on entry to DONE so it is already high during the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr     <= SEED_EFF;
      i        <= 4'd15;
      j        <= 4'd0;
      valid    <= 1'b0;
      card_map <= INIT_MAP;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        FILL: begin
          card_map <= INIT_MAP;
          valid    <= 1'b0;
          i        <= 4'd15;
        end
        DRAW: if (draw_ok) j <= r;
        SWAP: begin
          card_map[{i, 2'b00} +: 4] <= card_map[{j, 2'b00} +: 4];
          card_map[{j, 2'b00} +: 4] <= card_map[{i, 2'b00} +: 4];
          if (i == 4'd1) valid <= 1'b1;
          else           i     <= i - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
`timescale 1ns/1ps
// Directed bench for deck_shuffler: reset values, shuffles against an
// algorithmic Fisher-Yates model, ignored starts, mid-run reset, SEED=0.
module tb_deck_shuffler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        valid;
  logic [63:0] card_map;
  logic        busy_z;
  logic        done_z;
  logic        valid_z;
  logic [63:0] card_map_z;

  logic [15:0] m_lfsr;
  logic [15:0] m_lfsr_z;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [63:0] INIT_MAP = 64'h7766554433221100;

  deck_shuffler #(.SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .valid(valid), .card_map(card_map)
  );

  deck_shuffler #(.SEED(16'h0000)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy_z), .done(done_z), .valid(valid_z), .card_map(card_map_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSRs stepping once per clock from their effective seeds.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr   <= 16'hACE1;
      m_lfsr_z <= 16'h0001;
    end else begin
      m_lfsr   <= lfsr_next(m_lfsr);
      m_lfsr_z <= lfsr_next(m_lfsr_z);
    end
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit pairs_ok(input logic [63:0] m);
    int cnt[8];
    for (int s = 0; s < 8; s++) cnt[s] = 0;
    for (int k = 0; k < 16; k++) begin
      if (m[4*k+3]) return 1'b0;
      cnt[m[4*k +: 3]]++;
    end
    for (int s = 0; s < 8; s++) if (cnt[s] != 2) return 1'b0;
    return 1'b1;
  endfunction

  // v0 is the LFSR value during the FILL cycle; lat is the DONE cycle index
  // counted from the start edge (FILL = 1).
  task automatic model_shuffle(input logic [15:0] v0, output logic [63:0] m, output int lat);
    logic [3:0]  slot [16];
    logic [15:0] v;
    logic [3:0]  msk;
    logic [3:0]  r;
    logic [3:0]  tmp;
    int          cyc;
    for (int k = 0; k < 16; k++) slot[k] = 4'(k / 2);
    v   = lfsr_next(v0);
    cyc = 2;
    for (int i = 15; i >= 1; i--) begin
      msk = (i >= 8) ? 4'hF : (i >= 4) ? 4'h7 : (i >= 2) ? 4'h3 : 4'h1;
      r   = v[3:0] & msk;
      while (int'(r) > i) begin
        v = lfsr_next(v);
        cyc++;
        r = v[3:0] & msk;
      end
      tmp     = slot[i];
      slot[i] = slot[r];
      slot[r] = tmp;
      v   = lfsr_next(lfsr_next(v));
      cyc = cyc + 2;
    end
    for (int k = 0; k < 16; k++) m[4*k +: 4] = slot[k];
    lat = cyc;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // done cycle plus 'post' further cycles.
  task automatic apply_stimulus(input bit poke, input int post, output logic [63:0] map_out);
    logic [15:0] fill_v;
    logic [63:0] exp_map;
    int          exp_lat;
    int          lat;
    int          dones;
    int          k;
    int          after;
    bit          busy_late;
    map_out = '0;
    start   = 1'b1;
    @(posedge clk);
    #1 fill_v = m_lfsr;
    @(negedge clk);
    start = 1'b0;
    model_shuffle(fill_v, exp_map, exp_lat);
    check_output("busy_after_start", 64'(busy), 64'd1);
    k = 1; lat = 0; dones = 0; after = 0; busy_late = 1'b0;
    while (k < 2000 && (lat == 0 || after < post)) begin
      @(negedge clk);
      k++;
      start = poke && (k >= 2) && (k <= 4);
      if (lat != 0) begin
        after++;
        if (busy) busy_late = 1'b1;
      end
      if (k == 2) check_output("valid_cleared", 64'(valid), 64'd0);
      if (done) begin
        dones++;
        if (lat == 0) begin
          lat     = k;
          map_out = card_map;
          check_output("valid_at_done", 64'(valid), 64'd1);
          check_output("map_vs_model", card_map, exp_map);
          check_output("map_pairs", 64'(pairs_ok(card_map)), 64'd1);
          if (poke) start = 1'b1;
        end
      end
    end
    start = 1'b0;
    if (lat == 0) check_output("done_timeout", 64'd0, 64'd1);
    else          check_output("done_latency", 64'(lat), 64'(exp_lat));
    if (post > 0) begin
      check_output("done_count", 64'(dones), 64'd1);
      check_output("no_restart", 64'(busy_late), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] map_a;
    logic [63:0] map_b;
    logic [63:0] map_c;
    logic [63:0] map_t;
    logic [63:0] exp_map;
    logic [15:0] fill_v;
    int          exp_lat;
    int          lat;
    int          k;
    int          dones;
    bit          zero_seen;

    reset_dut();
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_valid", 64'(valid), 64'd0);
    check_output("rst_map", card_map, INIT_MAP);
    check_output("rst_lfsr", 64'(dut.lfsr), 64'h0000_0000_0000_ACE1);
    check_output("rst_lfsr_seed0", 64'(dut_z.lfsr), 64'd1);

    repeat (10) @(negedge clk);
    apply_stimulus(1'b0, 60, map_a);

    reset_dut();
    repeat (10) @(negedge clk);
    apply_stimulus(1'b1, 60, map_b);
    check_output("ignored_start_same_map", map_b, map_a);

    reset_dut();
    repeat (11) @(negedge clk);
    apply_stimulus(1'b0, 60, map_c);
    check_output("start_shift_differs", 64'(map_c != map_a), 64'd1);

    reset_dut();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midrst_busy", 64'(busy), 64'd0);
    check_output("midrst_valid", 64'(valid), 64'd0);
    check_output("midrst_done", 64'(done), 64'd0);
    check_output("midrst_map", card_map, INIT_MAP);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_output("midrst_no_done", 64'(dones), 64'd0);

    reset_dut();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 fill_v = m_lfsr_z;
    @(negedge clk);
    start = 1'b0;
    model_shuffle(fill_v, exp_map, exp_lat);
    k = 1; lat = 0; zero_seen = 1'b0;
    while (k < 2000 && lat == 0) begin
      @(negedge clk);
      k++;
      if (dut_z.lfsr == 16'h0000) zero_seen = 1'b1;
      if (done_z) lat = k;
    end
    check_output("seed0_latency", 64'(lat), 64'(exp_lat));
    check_output("seed0_map", card_map_z, exp_map);
    check_output("seed0_valid", 64'(valid_z), 64'd1);
    check_output("seed0_lfsr_nonzero", 64'(zero_seen), 64'd0);
    check_output("seed0_lfsr_track", 64'(dut_z.lfsr), 64'(m_lfsr_z));

    reset_dut();
    repeat (10) @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      apply_stimulus(1'b0, 0, map_t);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
